// File: rtl/i2s_transmit_24.sv
// rtl/i2s_transmit_24.sv - Philips I2S stereo transmitter with a one-pair holding register
// Optional build macro: I2S_TX_REPEAT_ON_UNDERRUN_EN (repeat last pair on underrun instead of muting)
module i2s_transmit_24 #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              underrun_o,
    output logic              active_o
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sck_q;
    logic                ws_q, ws_d;
    logic                sd_q, sd_d;
    logic [SLOT_W-1:0]   shreg_q, shreg_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_left_q, hold_left_d;
    logic [DATA_W-1:0]   hold_right_q, hold_right_d;
    logic [DATA_W-1:0]   right_act_q, right_act_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [DATA_W-1:0]   last_left_q, last_left_d;
`endif

    logic                sck_fall;
    logic                ws_edge;
    logic                left_start;
    logic                right_start;
    logic                accept;
    logic [DATA_W-1:0]   left_word;
    logic [DATA_W-1:0]   under_left;
    logic [DATA_W-1:0]   under_right;

    // Word sits at the top of the slot; the remaining low bits shift out as zeros.
    function automatic logic [SLOT_W-1:0] slot_word(input logic [DATA_W-1:0] w);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_W-1 -: DATA_W] = w;
        return s;
    endfunction

    assign sck_fall    = sck_q & ~sck_i;
    assign ws_edge     = sck_fall & (ws_i ^ ws_q);
    assign left_start  = ws_edge & ~ws_i & (state_q != LEFT);
    assign right_start = ws_edge & ws_i & (state_q == LEFT);
    assign accept      = valid_i & ~hold_valid_q;

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    assign under_left  = last_left_q;
    assign under_right = right_act_q;
`else
    assign under_left  = '0;
    assign under_right = '0;
`endif

    assign left_word  = hold_valid_q ? hold_left_q : under_left;
    assign underrun_o = left_start & ~hold_valid_q;
    assign ready_o    = ~hold_valid_q;
    assign sd_o       = sd_q;
    assign active_o   = (state_q != SYNC);

    always_comb begin
        state_d      = state_q;
        ws_d         = ws_q;
        sd_d         = sd_q;
        shreg_d      = shreg_q;
        hold_valid_d = hold_valid_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        right_act_d  = right_act_q;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
        last_left_d  = last_left_q;
`endif

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_left_d  = left_i;
            hold_right_d = right_i;
        end

        if (sck_fall) begin
            ws_d = ws_i;
            if (state_q == SYNC) begin
                sd_d    = 1'b0;
                shreg_d = '0;
            end else begin
                // Old MSB still goes out on a ws edge, giving the one-SCK I2S delay.
                sd_d    = shreg_q[SLOT_W-1];
                shreg_d = shreg_q << 1;
            end
            if (left_start) begin
                state_d = LEFT;
                shreg_d = slot_word(left_word);
            end else if (right_start) begin
                state_d = RIGHT;
                shreg_d = slot_word(right_act_q);
            end
        end

        if (left_start) begin
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_d = left_word;
`endif
            if (hold_valid_q) begin
                right_act_d  = hold_right_q;
                hold_valid_d = 1'b0;
            end else begin
                right_act_d  = under_right;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= SYNC;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            sd_q         <= 1'b0;
            shreg_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            right_act_q  <= '0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sck_q        <= sck_i;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            shreg_q      <= shreg_d;
            hold_valid_q <= hold_valid_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            right_act_q  <= right_act_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
            last_left_q  <= last_left_d;
`endif
        end
    end

endmodule
